hilo_ctrl: RTL and testbench
============================

HILO_CTRL -- requirements
Module: hilo_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 48, meaning max cycles in WAIT before the watchdog aborts.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 op_valid  in  1  EX-stage HI/LO-class instruction present.
REQ-005 op  in  3  0 NOP, 1 MULT, 2 MULTU, 3 MTHI, 4 MTLO, 5 MFHI, 6 MFLO, 7 reserved (treated as NOP).
REQ-006 rs_val  in  32  first operand / MTHI-MTLO source.
REQ-007 rt_val  in  32  second operand.
REQ-008 stall  out  1  pipeline hold request; upstream keeps op/operands stable while high.
REQ-009 rd_data  out  32  MFHI/MFLO result.
REQ-010 hi, lo  out  32 each  architectural HI/LO registers.
REQ-011 err  out  1  sticky watchdog flag.
REQ-012 mul_start  out  1  one-cycle start pulse to the external signed 32x32 multiplier.
REQ-013 mul_a, mul_b  out  32 each  registered multiplier operands.
REQ-014 mul_busy  in  1  multiplier busy; rises the cycle after mul_start, falls when mul_z is valid.
REQ-015 mul_z  in  64  signed product, valid while mul_busy=0 after completion.

Function
REQ-016 An op SHALL be accepted in a cycle where op_valid=1 and stall=0.
REQ-017 FSM states SHALL be IDLE, START, WAIT, FIX; IDLE->START on accepted MULT/MULTU; START->WAIT unconditionally; WAIT->FIX when mul_busy=0; WAIT->IDLE on watchdog expiry; FIX->IDLE unconditionally.
REQ-018 On accept of MULT/MULTU the block SHALL register rs_val, rt_val and an unsigned flag.
REQ-019 In START, mul_start SHALL be 1 with mul_a/mul_b holding the registered operands; mul_start SHALL be 0 in every other state.
REQ-020 In FIX, {hi,lo} SHALL be loaded at the clock edge with mul_z for MULT, or with mul_z + (a[31] ? b<<32 : 0) + (b[31] ? a<<32 : 0), mod 2^64, for MULTU.
REQ-021 stall SHALL be 1 in START, WAIT and FIX.
REQ-021 (cont.) In IDLE, stall SHALL be 0, so the accept cycle itself does not stall.
REQ-022 MTHI/MTLO accepted in IDLE SHALL write rs_val to hi/lo at the accept edge, with no stall.
REQ-023 MFHI/MFLO accepted in IDLE SHALL drive rd_data = hi/lo combinationally in the same cycle; otherwise rd_data SHALL be 0.
REQ-024 Any op presented while not IDLE SHALL see stall=1 and be accepted only after return to IDLE, so MFHI/MFLO read the new product.
REQ-025 A WAIT-cycle counter SHALL reset on entering WAIT; on reaching TIMEOUT, err SHALL set, state SHALL go to IDLE, and hi/lo SHALL be unchanged.
REQ-026 err SHALL clear only on reset.

Reset
REQ-027 On reset: state IDLE, hi=lo=0, err=0, mul_start=0, mul_a=mul_b=0, counter=0, stall=0, rd_data=0.
REQ-028 Reset mid-operation SHALL abandon the product with no HI/LO write; the multiplier is reset by the same reset.

Structure
REQ-029 A shared package SHALL hold the op encodings, the FSM state encoding, and the TIMEOUT default.
REQ-030 The MULTU correction adder SHALL be a sub-module, hilo_ucorr (64-bit combinational), instantiated once.
REQ-031 The multiplier SHALL stay external and connect only through the mul_* ports.

Verification
REQ-032 MULT rs=0xFFFFFFFD, rt=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB after FIX; stall high from accept+1 through FIX.
REQ-033 MULTU rs=rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-034 MULT 5x6, then MFLO held during stall -> MFLO accepted the first IDLE cycle with rd_data=0x0000001E.
REQ-035 MTHI rs=0x12345678 in IDLE, then MFHI next cycle -> stall=0 throughout, rd_data=0x12345678.
REQ-036 Reset asserted in the 10th WAIT cycle -> next cycle IDLE, hi=lo=0, stall=0, no later write.
REQ-037 TIMEOUT=48 with mul_busy stuck at 1 -> err=1 after 48 WAIT cycles, IDLE, hi/lo unchanged.

Source files
------------

// File: rtl/hilo_ctrl_pkg.sv
// Shared definitions for the HI/LO control block: op encodings, FSM states
// and the default watchdog limit.
package hilo_ctrl_pkg;

  localparam int unsigned TIMEOUT_DEFAULT = 48;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_MTHI  = 3'd3,
    OP_MTLO  = 3'd4,
    OP_MFHI  = 3'd5,
    OP_MFLO  = 3'd6,
    OP_RSVD  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_FIX   = 2'd3
  } state_e;

endpackage

// File: rtl/hilo_ucorr.sv
// MULTU correction: turns a signed 32x32 product into the unsigned product
// by adding back the operand contributions lost to sign interpretation.
module hilo_ucorr (
  input  logic [63:0] i_z,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [63:0] o_z
);

  logic [63:0] w_add_a;
  logic [63:0] w_add_b;

  // A negative-looking a contributes an extra b*2^32, and vice versa
  always_comb begin
    w_add_a = i_a[31] ? {i_b, 32'h0} : '0;
    w_add_b = i_b[31] ? {i_a, 32'h0} : '0;
    o_z     = i_z + w_add_a + w_add_b;
  end

endmodule

// File: rtl/hilo_ctrl.sv
// HI/LO register control: MTHI/MTLO/MFHI/MFLO handling and sequencing of an
// external signed multiplier for MULT/MULTU, with a WAIT-state watchdog.
module hilo_ctrl
  import hilo_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        stall,
  output logic [31:0] rd_data,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        err,
  output logic        mul_start,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic        mul_busy,
  input  logic [63:0] mul_z
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e        r_state;
  state_e        w_next;
  op_e           w_op;
  logic          w_accept;
  logic          w_is_mul;
  logic          w_timeout;
  logic [31:0]   r_a;
  logic [31:0]   r_b;
  logic          r_uns;
  logic [CW-1:0] r_cnt;
  logic [63:0]   w_ucorr;
  logic [63:0]   w_prod;

  assign w_op     = op_e'(op);
  assign w_accept = op_valid && (r_state == ST_IDLE);
  assign w_is_mul = (w_op == OP_MULT) || (w_op == OP_MULTU);
  assign mul_a    = r_a;
  assign mul_b    = r_b;

  hilo_ucorr u_ucorr (
    .i_z (mul_z),
    .i_a (r_a),
    .i_b (r_b),
    .o_z (w_ucorr)
  );

  assign w_prod = r_uns ? w_ucorr : mul_z;

  // FSM next state, stall, start pulse and watchdog expiry
  always_comb begin
    w_next    = r_state;
    stall     = 1'b1;
    mul_start = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      ST_IDLE: begin
        stall = 1'b0;
        if (w_accept && w_is_mul) w_next = ST_START;
      end
      ST_START: begin
        mul_start = 1'b1;
        w_next    = ST_WAIT;
      end
      ST_WAIT: begin
        // A completed product wins over a simultaneous watchdog expiry
        if (!mul_busy) begin
          w_next = ST_FIX;
        end else if (r_cnt == CW'(TIMEOUT - 1)) begin
          w_next    = ST_IDLE;
          w_timeout = 1'b1;
        end
      end
      ST_FIX:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // MFHI/MFLO read port, only live on an accepted read
  always_comb begin
    rd_data = '0;
    if (w_accept && (w_op == OP_MFHI)) rd_data = hi;
    if (w_accept && (w_op == OP_MFLO)) rd_data = lo;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Multiplier operand capture on accepted MULT/MULTU
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a   <= '0;
      r_b   <= '0;
      r_uns <= 1'b0;
    end else if (w_accept && w_is_mul) begin
      r_a   <= rs_val;
      r_b   <= rt_val;
      r_uns <= (w_op == OP_MULTU);
    end
  end

  // HI/LO architectural registers
  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (r_state == ST_FIX) begin
      {hi, lo} <= w_prod;
    end else begin
      if (w_accept && (w_op == OP_MTHI)) hi <= rs_val;
      if (w_accept && (w_op == OP_MTLO)) lo <= rs_val;
    end
  end

  // WAIT-cycle counter, cleared on the way into WAIT
  always_ff @(posedge clk) begin
    if (reset)                     r_cnt <= '0;
    else if (r_state == ST_START)  r_cnt <= '0;
    else if (r_state == ST_WAIT)   r_cnt <= r_cnt + CW'(1);
  end

  // Sticky watchdog flag
  always_ff @(posedge clk) begin
    if (reset)          err <= 1'b0;
    else if (w_timeout) err <= 1'b1;
  end

endmodule

// File: tb/tb_hilo_ctrl.sv
// Randomized self-checking bench for hilo_ctrl with a behavioural
// multiplier device and an architectural HI/LO reference model.
module tb_hilo_ctrl;
  import hilo_ctrl_pkg::*;

  localparam int TO = 48;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] rs_val, rt_val;
  logic        stall;
  logic [31:0] rd_data, hi, lo;
  logic        err;
  logic        mul_start;
  logic [31:0] mul_a, mul_b;
  logic        mul_busy;
  logic [63:0] mul_z;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_hi, m_lo;
  logic        m_err;

  // external multiplier device
  logic        mm_busy = 1'b0;
  logic [63:0] mm_z = '0, mm_prod = '0;
  int          mm_cnt = 0;
  int          mm_lat = 3;
  logic        mm_stuck = 1'b0;

  assign mul_busy = mm_busy;
  assign mul_z    = mm_z;

  hilo_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .stall(stall), .rd_data(rd_data),
    .hi(hi), .lo(lo), .err(err), .mul_start(mul_start),
    .mul_a(mul_a), .mul_b(mul_b), .mul_busy(mul_busy), .mul_z(mul_z)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) begin
      mm_busy <= 1'b0;
      mm_cnt  <= 0;
    end else if (mul_start) begin
      mm_busy <= 1'b1;
      mm_cnt  <= mm_lat;
      mm_prod <= 64'(longint'($signed(mul_a)) * longint'($signed(mul_b)));
      mm_z    <= {$urandom, $urandom};
    end else if (mm_busy && !mm_stuck) begin
      if (mm_cnt <= 1) begin
        mm_busy <= 1'b0;
        mm_z    <= mm_prod;
      end else begin
        mm_cnt <= mm_cnt - 1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] ua, ub;
    if (o == OP_MULT) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = {32'h0, a};
    ub = {32'h0, b};
    return ua * ub;
  endfunction

  task automatic check_arch();
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    chk("err", err, m_err);
  endtask

  // Present an op at a negedge, hold it through any stall, return stall count
  task automatic issue(input logic [2:0] o, input logic [31:0] rs, input logic [31:0] rt, output int stalls);
    logic [31:0] exp_rd;
    int n = 0;
    op_valid = 1'b1; op = o; rs_val = rs; rt_val = rt;
    #1;
    while (stall && n < 300) begin
      chk("rd_data_stalled", rd_data, 0);
      n++;
      @(negedge clk); #1;
    end
    chk("accept_stall", stall, 0);
    exp_rd = (o == OP_MFHI) ? m_hi : (o == OP_MFLO) ? m_lo : 32'h0;
    chk("rd_data", rd_data, exp_rd);
    @(posedge clk);
    if (o == OP_MTHI) m_hi = rs;
    if (o == OP_MTLO) m_lo = rs;
    @(negedge clk);
    op_valid = 1'b0; op = $urandom_range(0, 7); rs_val = $urandom; rt_val = $urandom;
    stalls = n;
  endtask

  // Count busy cycles after a multiply was accepted
  task automatic wait_idle(input logic [31:0] a, input logic [31:0] b, output int cyc);
    int starts = 0;
    cyc = 0;
    while (stall && cyc < 300) begin
      if (mul_start) begin
        starts++;
        chk("mul_a", mul_a, a);
        chk("mul_b", mul_b, b);
      end
      cyc++;
      @(negedge clk);
    end
    chk("start_pulses", starts, 1);
    chk("mul_start_idle", mul_start, 0);
  endtask

  task automatic do_mul(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input int lat);
    int s, c;
    mm_lat = lat;
    issue(o, a, b, s);
    chk("mul_accept_stalls", s, 0);
    wait_idle(a, b, c);
    if (mm_stuck) begin
      chk("timeout_cycles", c, 1 + TO);
      m_err = 1'b1;
    end else begin
      chk("mul_stall_cycles", c, lat + 3);
      {m_hi, m_lo} = ref_mul(o, a, b);
    end
    check_arch();
  endtask

  initial begin
    int s, s2;
    logic [2:0]  ro;
    logic [31:0] ra, rb;

    reset = 1'b1; op_valid = 1'b0; op = '0; rs_val = '0; rt_val = '0;
    m_hi = '0; m_lo = '0; m_err = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_stall", stall, 0);
    chk("rst_mul_start", mul_start, 0);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_mul_b", mul_b, 0);
    chk("rst_rd_data", rd_data, 0);
    check_arch();
    reset = 1'b0;
    @(negedge clk);

    // signed multiply of a negative operand
    do_mul(OP_MULT, 32'hFFFFFFFD, 32'd7, 4);
    chk("mult_neg_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);

    // unsigned all-ones squared
    do_mul(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 2);
    chk("multu_ones_const", {hi, lo}, 64'hFFFFFFFE_00000001);

    // MFLO held behind a running MULT reads the new product
    mm_lat = 3;
    issue(OP_MULT, 32'd5, 32'd6, s);
    {m_hi, m_lo} = ref_mul(OP_MULT, 32'd5, 32'd6);
    issue(OP_MFLO, 32'h0, 32'h0, s2);
    chk("mflo_held_stalls", s2, 6);
    chk("mflo_lo_const", lo, 32'h1E);
    check_arch();

    // MTHI then MFHI with no stall
    issue(OP_MTHI, 32'h12345678, 32'h0, s);
    chk("mthi_stalls", s, 0);
    check_arch();
    issue(OP_MFHI, 32'h0, 32'h0, s);
    chk("mfhi_stalls", s, 0);
    chk("mfhi_const", hi, 32'h12345678);

    // random mix of ops
    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom; rb = $urandom;
      if (i % 5 == 0) begin ra[31] = 1'b1; end
      if (ro == OP_MULT || ro == OP_MULTU) begin
        do_mul(ro, ra, rb, $urandom_range(1, 12));
      end else begin
        issue(ro, ra, rb, s);
        chk("op_stalls", s, 0);
        check_arch();
      end
      if ($urandom_range(0, 3) == 0) begin
        op = OP_MFHI; op_valid = 1'b0; #1;
        chk("rd_data_novalid", rd_data, 0);
        @(negedge clk);
      end
    end

    // watchdog with the multiplier stuck busy
    mm_stuck = 1'b1;
    do_mul(OP_MULT, 32'h00000123, 32'h00000456, 5);
    mm_stuck = 1'b0;
    // err stays set across later successful operations
    do_mul(OP_MULTU, 32'h80000001, 32'h00000003, 3);
    issue(OP_MTLO, 32'hCAFEF00D, 32'h0, s);
    check_arch();

    // reset in the 10th WAIT cycle abandons the product
    mm_lat = 20;
    issue(OP_MULT, 32'h00001000, 32'h00002000, s);
    repeat (10) @(negedge clk);
    chk("pre_reset_stall", stall, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_hi = '0; m_lo = '0; m_err = 1'b0;
    chk("post_reset_stall", stall, 0);
    chk("post_reset_mul_start", mul_start, 0);
    chk("post_reset_mul_a", mul_a, 0);
    chk("post_reset_rd_data", rd_data, 0);
    check_arch();
    repeat (30) @(negedge clk);
    chk("late_stall", stall, 0);
    check_arch();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
